// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM with clear engine:
// FSM state encoding and the legal read-latency range.
package sp_ram_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/sp_ram_core.sv
// Plain storage array: byte-enabled write port and a single registered read stage.
// The read register only updates on a read, so it holds between reads.
module sp_ram_core #(
   parameter int DW = 8,
   parameter int AW = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   din,
   input  logic [DW/8-1:0] be,
   output logic [DW-1:0]   q
);

   localparam int NB = DW / 8;

   logic [DW-1:0] mem [2**AW];

   // Array is deliberately not reset; only the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            q <= '0;
      else if (en && !we) q <= mem[addr];
   end

endmodule

// File: rtl/sp_ram_sync_clr.sv
// Single-port synchronous RAM with byte enables, 1- or 2-cycle read latency
// with a read-valid strobe, and a clear engine that sweeps every address.
module sp_ram_sync_clr
   import sp_ram_pkg::*;
#(
   parameter int            DW             = 8,
   parameter int            AW             = 10,
   parameter int            RD_LAT         = 1,
   parameter logic [DW-1:0] INIT_VAL       = '0,
   parameter bit            CLEAR_ON_RESET = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sel,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   din,
   input  logic [DW/8-1:0] be,
   input  logic            clr_req,
   output logic [DW-1:0]   dout,
   output logic            rd_valid,
   output logic            busy
);

   localparam logic [AW-1:0] LAST_ADDR = '1;

   if (DW % 8 != 0) begin : g_dw_err
      $error("sp_ram_sync_clr: DW must be a multiple of 8");
   end
   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_err
      $error("sp_ram_sync_clr: RD_LAT must be 1 or 2");
   end

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_addr;
   logic              access, rd_req;
   logic              core_en, core_we;
   logic [AW-1:0]     core_addr;
   logic [DW-1:0]     core_din, core_q;
   logic [DW/8-1:0]   core_be;
   logic [RD_LAT:1]   vld_pipe;

   assign busy   = (state == ST_CLEAR);
   assign access = sel && !busy && !rst;
   assign rd_req = access && !we;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
         ST_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_addr <= '0;
      end else begin
         state <= state_nxt;
         if (busy) clr_addr <= clr_addr + 1'b1;
      end
   end

   // The sweep owns the port while busy; user accesses are simply dropped.
   assign core_en   = !rst && (busy || sel);
   assign core_we   = busy || we;
   assign core_addr = busy ? clr_addr : addr;
   assign core_din  = busy ? INIT_VAL : din;
   assign core_be   = busy ? '1 : be;

   sp_ram_core #(.DW(DW), .AW(AW)) u_core (
      .clk  (clk),
      .rst  (rst),
      .en   (core_en),
      .we   (core_we),
      .addr (core_addr),
      .din  (core_din),
      .be   (core_be),
      .q    (core_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= rd_req;
         for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   assign rd_valid = vld_pipe[RD_LAT];

   if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] q2;
      always_ff @(posedge clk) begin
         if (rst)              q2 <= '0;
         else if (vld_pipe[1]) q2 <= core_q;
      end
      assign dout = q2;
   end else begin : g_lat1
      assign dout = core_q;
   end

endmodule

// File: tb/tb_sp_ram_sync_clr.sv
// Directed bench for sp_ram_sync_clr: an 8-bit/RD_LAT=1 instance and a
// 16-bit/RD_LAT=2 instance, with read results checked against a scoreboard.
module tb_sp_ram_sync_clr;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic       a_sel, a_we, a_clr;
   logic [9:0] a_addr;
   logic [7:0] a_din, a_dout;
   logic [0:0] a_be;
   logic       a_vld, a_busy;

   logic        b_sel, b_we, b_clr;
   logic [9:0]  b_addr;
   logic [15:0] b_din, b_dout;
   logic [1:0]  b_be;
   logic        b_vld, b_busy;

   logic [15:0] qa_dat[$], qb_dat[$];
   int          qa_cyc[$], qb_cyc[$];

   sp_ram_sync_clr #(.DW(8), .AW(10), .RD_LAT(1), .INIT_VAL(8'h00), .CLEAR_ON_RESET(1'b1)) dut_a (
      .clk(clk), .rst(rst), .sel(a_sel), .we(a_we), .addr(a_addr), .din(a_din), .be(a_be),
      .clr_req(a_clr), .dout(a_dout), .rd_valid(a_vld), .busy(a_busy)
   );

   sp_ram_sync_clr #(.DW(16), .AW(10), .RD_LAT(2), .INIT_VAL(16'h0000), .CLEAR_ON_RESET(1'b1)) dut_b (
      .clk(clk), .rst(rst), .sel(b_sel), .we(b_we), .addr(b_addr), .din(b_din), .be(b_be),
      .clr_req(b_clr), .dout(b_dout), .rd_valid(b_vld), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every rd_valid must match the oldest outstanding read in data and cycle.
   always @(negedge clk) begin
      if (a_vld === 1'b1) begin
         if (qa_dat.size() == 0) chk("a_unexpected_rd_valid", 32'd1, 32'd0);
         else begin
            chk("a_rd_data", 32'(a_dout), 32'(qa_dat.pop_front()));
            chk("a_rd_cycle", cyc, qa_cyc.pop_front());
         end
      end
      if (b_vld === 1'b1) begin
         if (qb_dat.size() == 0) chk("b_unexpected_rd_valid", 32'd1, 32'd0);
         else begin
            chk("b_rd_data", 32'(b_dout), 32'(qb_dat.pop_front()));
            chk("b_rd_cycle", cyc, qb_cyc.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_a(input logic [9:0] ad, input logic [7:0] ex);
      a_sel = 1'b1; a_we = 1'b0; a_addr = ad;
      qa_dat.push_back(16'(ex));
      qa_cyc.push_back(cyc + 1);
      tick();
   endtask

   task automatic rd_b(input logic [9:0] ad, input logic [15:0] ex);
      b_sel = 1'b1; b_we = 1'b0; b_addr = ad;
      qb_dat.push_back(ex);
      qb_cyc.push_back(cyc + 2);
      tick();
   endtask

   task automatic wr_b(input logic [9:0] ad, input logic [15:0] d, input logic [1:0] bytes);
      b_sel = 1'b1; b_we = 1'b1; b_addr = ad; b_din = d; b_be = bytes;
      tick();
   endtask

   task automatic count_busy(input bit which_b, output int n);
      n = 0;
      while (((which_b ? b_busy : a_busy) === 1'b1) && n < 3000) begin
         tick();
         n++;
      end
   endtask

   int n, m;

   initial begin
      rst = 1'b1;
      a_sel = 0; a_we = 0; a_clr = 0; a_addr = '0; a_din = '0; a_be = '1;
      b_sel = 0; b_we = 0; b_clr = 0; b_addr = '0; b_din = '0; b_be = '1;
      repeat (3) tick();
      chk("rst_a_dout", 32'(a_dout), 32'd0);
      chk("rst_a_vld", 32'(a_vld), 32'd0);
      chk("rst_a_busy", 32'(a_busy), 32'd1);
      chk("rst_b_dout", 32'(b_dout), 32'd0);
      chk("rst_b_vld", 32'(b_vld), 32'd0);
      chk("rst_b_busy", 32'(b_busy), 32'd1);

      // Power-up sweep length and cleared contents
      rst = 1'b0;
      count_busy(1'b0, n);
      chk("t1_busy_len", n, 1024);
      chk("t1_b_idle", 32'(b_busy), 32'd0);
      rd_a(10'h3FF, 8'h00);
      a_sel = 1'b0;
      tick();
      chk("t1_vld_drop", 32'(a_vld), 32'd0);

      // Fill both arrays with (2k)%256
      for (int k = 0; k < 1024; k++) begin
         a_sel = 1'b1; a_we = 1'b1; a_addr = k[9:0]; a_din = 8'(2 * k); a_be = 1'b1;
         b_sel = 1'b1; b_we = 1'b1; b_addr = k[9:0]; b_din = 16'((2 * k) % 256); b_be = 2'b11;
         tick();
      end
      a_sel = 1'b0; b_sel = 1'b0;
      rd_a(10'd5, 8'h0A);
      rd_a(10'd200, 8'h90);
      a_sel = 1'b0;
      repeat (2) tick();
      chk("t2_dout_hold", 32'(a_dout), 32'h90);
      chk("t2_vld_low", 32'(a_vld), 32'd0);

      // Pipelined back-to-back reads at latency 2
      rd_b(10'd1, 16'h0002);
      rd_b(10'd2, 16'h0004);
      rd_b(10'd3, 16'h0006);
      b_sel = 1'b0;
      repeat (3) tick();
      chk("t4_drained", qb_dat.size(), 0);

      // Partial byte write, then read right behind it
      wr_b(10'd3, 16'hABCD, 2'b11);
      wr_b(10'd3, 16'h1234, 2'b01);
      rd_b(10'd3, 16'hAB34);
      b_sel = 1'b0;
      repeat (3) tick();

      // Clear on request: coincident read completes, mid-sweep accesses dropped
      a_sel = 1'b1; a_we = 1'b0; a_addr = 10'd9; a_clr = 1'b1;
      qa_dat.push_back(16'h0012);
      qa_cyc.push_back(cyc + 1);
      tick();
      a_sel = 1'b0; a_clr = 1'b0;
      chk("t5_busy_start", 32'(a_busy), 32'd1);
      n = 0;
      repeat (100) begin tick(); n++; end
      a_sel = 1'b1; a_we = 1'b1; a_addr = 10'd7; a_din = 8'h55;
      tick(); n++;
      a_we = 1'b0;
      tick(); n++;
      a_sel = 1'b0; a_clr = 1'b1;
      tick(); n++;
      a_clr = 1'b0;
      count_busy(1'b0, m);
      chk("t5_busy_len", n + m, 1024);
      rd_a(10'd7, 8'h00);
      rd_a(10'd9, 8'h00);
      a_sel = 1'b0;
      repeat (2) tick();

      // Reset kills an in-flight read and restarts the sweep from 0
      b_sel = 1'b1; b_we = 1'b0; b_addr = 10'd1;
      tick();
      b_sel = 1'b0; rst = 1'b1;
      tick();
      chk("t6_b_vld", 32'(b_vld), 32'd0);
      chk("t6_b_dout", 32'(b_dout), 32'd0);
      chk("t6_a_dout", 32'(a_dout), 32'd0);
      chk("t6_b_busy", 32'(b_busy), 32'd1);
      rst = 1'b0;
      repeat (100) tick();
      chk("t6_mid_busy", 32'(b_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_busy(1'b1, n);
      chk("t6_busy_len", n, 1024);
      rd_b(10'd3, 16'h0000);
      b_sel = 1'b0;
      rd_a(10'd200, 8'h00);
      a_sel = 1'b0;
      repeat (3) tick();
      chk("end_qa_empty", qa_dat.size(), 0);
      chk("end_qb_empty", qb_dat.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
